// File: rtl/clink_seq_ctrl.sv
// clink_seq_ctrl: CLINK sequencing controller.
// Loads REC weights, captures samples, sweeps MVM rows and REC (iteration, channel)
// pairs for seq_len steps per run, and carries the hidden state between steps.
module clink_seq_ctrl #(
  parameter int unsigned DW      = 16,
  parameter int unsigned NH      = 5,
  parameter int unsigned W_DEPTH = 32,
  parameter int unsigned N_ITER  = 5,
  parameter int unsigned LUT_AW  = 10,
  parameter int unsigned SEQ_W   = 8,
  localparam int unsigned AW = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1,
  localparam int unsigned IW = (N_ITER > 1) ? $clog2(N_ITER) : 1,
  localparam int unsigned CW = (NH > 1) ? $clog2(NH) : 1,
  localparam int unsigned PW = $clog2(NH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 param_ld_start,
  input  logic [DW-1:0]        param_ld_data,
  input  logic                 param_set,
  output logic [(NH+1)*DW-1:0] rec_w,
  input  logic [DW-1:0]        clink_input,
  output logic [DW-1:0]        in_d,
  input  logic [NH*DW-1:0]     h_cur_d,
  output logic [NH*DW-1:0]     h_pre_d,
  input  logic                 h_clear,
  input  logic [SEQ_W-1:0]     seq_len,
  input  logic                 clink_start,
  input  logic                 clink_abort,
  output logic                 clink_busy,
  output logic                 clink_step_done,
  output logic                 clink_finish,
  output logic [SEQ_W-1:0]     step_cnt,
  output logic [AW-1:0]        weight_addr,
  output logic                 mvm_enable,
  output logic                 mvm_isTanh,
  output logic [IW-1:0]        iter_n,
  output logic [CW-1:0]        curr_s,
  input  logic [LUT_AW-1:0]    lut_mvm_addr,
  input  logic [LUT_AW-1:0]    lut_rec_addr,
  output logic [LUT_AW-1:0]    lut_addr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MVM  = 3'd1,
    REC  = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0]        weight_addr_q, weight_addr_d;
  logic [IW-1:0]        iter_n_q, iter_n_d;
  logic [CW-1:0]        curr_s_q, curr_s_d;
  logic                 mvm_enable_q, mvm_enable_d;
  logic                 mvm_is_tanh_q, mvm_is_tanh_d;
  logic                 busy_q, busy_d;
  logic                 step_done_q, step_done_d;
  logic                 finish_q, finish_d;
  logic [SEQ_W-1:0]     step_cnt_q, step_cnt_d;
  logic [SEQ_W-1:0]     seq_len_q, seq_len_d;
  logic [DW-1:0]        in_d_q, in_d_d;
  logic [NH*DW-1:0]     h_pre_d_q, h_pre_d_d;
  logic [(NH+1)*DW-1:0] rec_w_q, rec_w_d;
  logic [PW-1:0]        ld_idx_q, ld_idx_d;
  logic                 ld_armed_q, ld_armed_d;
  logic [PW-1:0]        ld_slot;

  logic start_acc;
  logic step_act;
  logic done_act;
  logic step_last;
  logic mvm_last;
  logic rec_last;

  // Qualified events; abort overrides start and the STEP/DONE actions
  assign start_acc = (state_q == IDLE) && clink_start && !clink_abort && (seq_len != '0);
  assign step_act  = (state_q == STEP) && !clink_abort;
  assign done_act  = (state_q == DONE) && !clink_abort;
  assign step_last = ((step_cnt_q + SEQ_W'(1)) == seq_len_q);
  assign mvm_last  = (weight_addr_q == AW'(W_DEPTH - 1));
  assign rec_last  = (iter_n_q == IW'(N_ITER - 1)) && (curr_s_q == CW'(NH - 1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clink_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_acc) state_d = MVM;
        MVM:     if (mvm_last) state_d = REC;
        REC:     if (rec_last) state_d = STEP;
        STEP:    state_d = step_last ? DONE : MVM;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sweep counters and status outputs, registered from the next state
  always_comb begin
    weight_addr_d = '0;
    iter_n_d      = '0;
    curr_s_d      = '0;
    if (state_q == MVM && state_d == MVM) begin
      weight_addr_d = weight_addr_q + AW'(1);
    end
    if (state_q == REC && state_d == REC) begin
      if (curr_s_q == CW'(NH - 1)) begin
        curr_s_d = '0;
        iter_n_d = iter_n_q + IW'(1);
      end else begin
        curr_s_d = curr_s_q + CW'(1);
        iter_n_d = iter_n_q;
      end
    end
    mvm_enable_d  = (state_d == MVM);
    mvm_is_tanh_d = (state_d == MVM) && (weight_addr_d >= AW'(W_DEPTH / 2));
    busy_d        = (state_d != IDLE);
    step_done_d   = step_act;
    finish_d      = done_act;
  end

  // Per-run context: sample, hidden state, step count, sequence length
  always_comb begin
    step_cnt_d = step_cnt_q;
    seq_len_d  = seq_len_q;
    in_d_d     = in_d_q;
    h_pre_d_d  = h_pre_d_q;
    if (start_acc) begin
      step_cnt_d = '0;
      seq_len_d  = seq_len;
      in_d_d     = clink_input;
      if (h_clear) h_pre_d_d = '0;
    end
    if (step_act) begin
      step_cnt_d = step_cnt_q + SEQ_W'(1);
      h_pre_d_d  = h_cur_d;
      if (!step_last) in_d_d = clink_input;
    end
  end

  // REC weight loader; a start pulse with data writes slot 0 in the same cycle
  always_comb begin
    rec_w_d    = rec_w_q;
    ld_idx_d   = ld_idx_q;
    ld_armed_d = ld_armed_q;
    ld_slot    = ld_idx_q;
    if (state_q == IDLE) begin
      if (param_ld_start) begin
        ld_idx_d   = '0;
        ld_armed_d = 1'b1;
        ld_slot    = '0;
      end
      if (param_set && (param_ld_start || ld_armed_q)) begin
        for (int unsigned k = 0; k < NH + 1; k++) begin
          if (ld_slot == PW'(k)) rec_w_d[k*DW +: DW] = param_ld_data;
        end
        ld_idx_d   = ld_slot + PW'(1);
        ld_armed_d = (ld_slot != PW'(NH));
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      weight_addr_q <= '0;
      iter_n_q      <= '0;
      curr_s_q      <= '0;
      mvm_enable_q  <= 1'b0;
      mvm_is_tanh_q <= 1'b0;
      busy_q        <= 1'b0;
      step_done_q   <= 1'b0;
      finish_q      <= 1'b0;
      step_cnt_q    <= '0;
      seq_len_q     <= '0;
      in_d_q        <= '0;
      h_pre_d_q     <= '0;
      rec_w_q       <= '0;
      ld_idx_q      <= '0;
      ld_armed_q    <= 1'b0;
    end else begin
      weight_addr_q <= weight_addr_d;
      iter_n_q      <= iter_n_d;
      curr_s_q      <= curr_s_d;
      mvm_enable_q  <= mvm_enable_d;
      mvm_is_tanh_q <= mvm_is_tanh_d;
      busy_q        <= busy_d;
      step_done_q   <= step_done_d;
      finish_q      <= finish_d;
      step_cnt_q    <= step_cnt_d;
      seq_len_q     <= seq_len_d;
      in_d_q        <= in_d_d;
      h_pre_d_q     <= h_pre_d_d;
      rec_w_q       <= rec_w_d;
      ld_idx_q      <= ld_idx_d;
      ld_armed_q    <= ld_armed_d;
    end
  end

  assign rec_w           = rec_w_q;
  assign in_d            = in_d_q;
  assign h_pre_d         = h_pre_d_q;
  assign clink_busy      = busy_q;
  assign clink_step_done = step_done_q;
  assign clink_finish    = finish_q;
  assign step_cnt        = step_cnt_q;
  assign weight_addr     = weight_addr_q;
  assign mvm_enable      = mvm_enable_q;
  assign mvm_isTanh      = mvm_is_tanh_q;
  assign iter_n          = iter_n_q;
  assign curr_s          = curr_s_q;

  // LUT address steering follows the current state directly
  assign lut_addr = (state_q == REC) ? lut_rec_addr : lut_mvm_addr;

endmodule

// File: tb/tb_clink_seq_ctrl.sv
// tb_clink_seq_ctrl: directed bench for clink_seq_ctrl (default parameters).
module tb_clink_seq_ctrl;

  localparam int unsigned DW   = 16;
  localparam int unsigned NH   = 5;
  localparam int          LAT  = 58;
  localparam logic [95:0] STD_W = 96'h0015_0014_0013_0012_0011_0010;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 param_ld_start;
  logic [DW-1:0]        param_ld_data;
  logic                 param_set;
  logic [(NH+1)*DW-1:0] rec_w;
  logic [DW-1:0]        clink_input;
  logic [DW-1:0]        in_d;
  logic [NH*DW-1:0]     h_cur_d;
  logic [NH*DW-1:0]     h_pre_d;
  logic                 h_clear;
  logic [7:0]           seq_len;
  logic                 clink_start;
  logic                 clink_abort;
  logic                 clink_busy;
  logic                 clink_step_done;
  logic                 clink_finish;
  logic [7:0]           step_cnt;
  logic [4:0]           weight_addr;
  logic                 mvm_enable;
  logic                 mvm_isTanh;
  logic [2:0]           iter_n;
  logic [2:0]           curr_s;
  logic [9:0]           lut_mvm_addr;
  logic [9:0]           lut_rec_addr;
  logic [9:0]           lut_addr;

  int n_vec = 0;
  int n_err = 0;

  clink_seq_ctrl dut (
    .clock(clock), .reset(reset),
    .param_ld_start(param_ld_start), .param_ld_data(param_ld_data), .param_set(param_set),
    .rec_w(rec_w), .clink_input(clink_input), .in_d(in_d),
    .h_cur_d(h_cur_d), .h_pre_d(h_pre_d), .h_clear(h_clear), .seq_len(seq_len),
    .clink_start(clink_start), .clink_abort(clink_abort), .clink_busy(clink_busy),
    .clink_step_done(clink_step_done), .clink_finish(clink_finish), .step_cnt(step_cnt),
    .weight_addr(weight_addr), .mvm_enable(mvm_enable), .mvm_isTanh(mvm_isTanh),
    .iter_n(iter_n), .curr_s(curr_s),
    .lut_mvm_addr(lut_mvm_addr), .lut_rec_addr(lut_rec_addr), .lut_addr(lut_addr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ld_start;
    logic        set;
    logic [15:0] data;
    logic [95:0] exp_w;
  } pvec_t;

  pvec_t pv[14];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [79:0] hval(input logic [15:0] b, input int k);
    logic [15:0] w;
    w = b + 16'(32'h1111 * k);
    return {5{w}};
  endfunction

  // Full run from start to the IDLE cycle after finish, checked every cycle
  task automatic run_seq(input int len, input logic [15:0] base, input logic [15:0] hb,
                         input logic clr, input logic [79:0] h_init);
    int p, k, kin, ks;
    logic [4:0] e_wa;
    logic [2:0] e_it, e_cs;
    logic       e_en, e_th, e_rec;
    seq_len = 8'(len); clink_input = base; h_clear = clr; h_cur_d = hval(hb, 0);
    clink_start = 1'b1;
    tick();
    clink_start = 1'b0; h_clear = 1'b0;
    for (int t = 0; t <= LAT * len + 1; t++) begin
      p = t % LAT; k = t / LAT;
      kin = (k < len) ? k : len - 1;
      ks  = (k < len) ? k : len;
      e_wa = '0; e_it = '0; e_cs = '0; e_en = 1'b0; e_th = 1'b0; e_rec = 1'b0;
      if (t < LAT * len) begin
        if (p < 32) begin
          e_en = 1'b1; e_wa = 5'(p); e_th = (p >= 16);
        end else if (p < 57) begin
          e_rec = 1'b1; e_it = 3'((p - 32) / 5); e_cs = 3'((p - 32) % 5);
        end
      end
      chk("busy", 128'(clink_busy), 128'(t <= LAT * len));
      chk("mvm_enable", 128'(mvm_enable), 128'(e_en));
      chk("weight_addr", 128'(weight_addr), 128'(e_wa));
      chk("mvm_isTanh", 128'(mvm_isTanh), 128'(e_th));
      chk("iter_n", 128'(iter_n), 128'(e_it));
      chk("curr_s", 128'(curr_s), 128'(e_cs));
      chk("lut_addr", 128'(lut_addr), e_rec ? 128'h2AA : 128'h055);
      chk("step_done", 128'(clink_step_done), 128'(t > 0 && p == 0 && k <= len));
      chk("finish", 128'(clink_finish), 128'(t == LAT * len + 1));
      chk("step_cnt", 128'(step_cnt), 128'(ks));
      chk("in_d", 128'(in_d), 128'(base + 16'(kin)));
      chk("h_pre_d", 128'(h_pre_d), (k == 0) ? 128'(h_init) : 128'(hval(hb, ks - 1)));
      chk("rec_w", 128'(rec_w), 128'(STD_W));
      // inputs for the next edge: junk sample except when STEP samples it
      h_cur_d     = hval(hb, k);
      clink_input = (p == 57) ? base + 16'(k + 1) : 16'hFFFF;
      clink_start = (t >= 5 && t <= 20);
      if (t == 5) seq_len = 8'd9;
      param_ld_start = (t == 10); param_set = (t == 10); param_ld_data = 16'hDEAD;
      tick();
    end
    param_ld_start = 1'b0; param_set = 1'b0;
  endtask

  initial begin
    pv[0]  = '{1'b1, 1'b0, 16'h0000, 96'h0};
    pv[1]  = '{1'b0, 1'b1, 16'h0010, 96'h0000_0000_0000_0000_0000_0010};
    pv[2]  = '{1'b0, 1'b1, 16'h0011, 96'h0000_0000_0000_0000_0011_0010};
    pv[3]  = '{1'b0, 1'b1, 16'h0012, 96'h0000_0000_0000_0012_0011_0010};
    pv[4]  = '{1'b0, 1'b1, 16'h0013, 96'h0000_0000_0013_0012_0011_0010};
    pv[5]  = '{1'b0, 1'b1, 16'h0014, 96'h0000_0014_0013_0012_0011_0010};
    pv[6]  = '{1'b0, 1'b1, 16'h0015, STD_W};
    pv[7]  = '{1'b0, 1'b1, 16'h0099, STD_W};
    pv[8]  = '{1'b0, 1'b0, 16'h0000, STD_W};
    pv[9]  = '{1'b1, 1'b1, 16'h0077, 96'h0015_0014_0013_0012_0011_0077};
    pv[10] = '{1'b0, 1'b1, 16'h0088, 96'h0015_0014_0013_0012_0088_0077};
    pv[11] = '{1'b1, 1'b1, 16'h0010, 96'h0015_0014_0013_0012_0088_0010};
    pv[12] = '{1'b0, 1'b1, 16'h0011, STD_W};
    pv[13] = '{1'b0, 1'b0, 16'h0000, STD_W};

    reset = 1'b1; param_ld_start = 1'b0; param_ld_data = '0; param_set = 1'b0;
    clink_input = '0; h_cur_d = '0; h_clear = 1'b0; seq_len = '0;
    clink_start = 1'b0; clink_abort = 1'b0;
    lut_mvm_addr = 10'h055; lut_rec_addr = 10'h2AA;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    chk("rst busy", 128'(clink_busy), 128'h0);
    chk("rst rec_w", 128'(rec_w), 128'h0);
    chk("rst in_d", 128'(in_d), 128'h0);
    chk("rst h_pre_d", 128'(h_pre_d), 128'h0);
    chk("rst step_cnt", 128'(step_cnt), 128'h0);
    chk("rst mvm_enable", 128'(mvm_enable), 128'h0);
    chk("rst pulses", 128'({clink_step_done, clink_finish}), 128'h0);
    chk("idle lut_addr", 128'(lut_addr), 128'h055);

    // weight loader table
    for (int i = 0; i < 14; i++) begin
      param_ld_start = pv[i].ld_start; param_set = pv[i].set; param_ld_data = pv[i].data;
      tick();
      chk("param rec_w", 128'(rec_w), 128'(pv[i].exp_w));
    end
    param_ld_start = 1'b0; param_set = 1'b0;

    // three-step run, hidden state carried; then one-step run with h_clear
    run_seq(3, 16'hB000, 16'h1111, 1'b0, 80'h0);
    run_seq(1, 16'hA000, 16'h0AAA, 1'b1, 80'h0);

    // abort in step 2 at REC iter_n=2
    seq_len = 8'd3; clink_input = 16'hC000; h_clear = 1'b0; h_cur_d = {5{16'h5555}};
    clink_start = 1'b1;
    tick();
    clink_start = 1'b0;
    for (int t = 0; t < 100; t++) begin
      clink_input = (t == 57) ? 16'hC001 : 16'hFFFF;
      tick();
    end
    chk("pre-abort iter_n", 128'(iter_n), 128'h2);
    chk("pre-abort curr_s", 128'(curr_s), 128'h0);
    chk("pre-abort step_cnt", 128'(step_cnt), 128'h1);
    h_cur_d = {5{16'hEEEE}}; clink_abort = 1'b1;
    tick();
    clink_abort = 1'b0;
    chk("abort busy", 128'(clink_busy), 128'h0);
    chk("abort counters", 128'({weight_addr, iter_n, curr_s, mvm_enable}), 128'h0);
    chk("abort h_pre_d", 128'(h_pre_d), 128'({5{16'h5555}}));
    chk("abort in_d", 128'(in_d), 128'hC001);
    chk("abort step_cnt", 128'(step_cnt), 128'h1);
    for (int t = 0; t < 70; t++) begin
      chk("post-abort idle", 128'({clink_busy, clink_step_done, clink_finish}), 128'h0);
      tick();
    end

    // seq_len==0 start is ignored
    seq_len = 8'd0; clink_input = 16'hD000; clink_start = 1'b1;
    tick();
    clink_start = 1'b0;
    chk("len0 busy", 128'(clink_busy), 128'h0);
    chk("len0 in_d", 128'(in_d), 128'hC001);
    tick();
    chk("len0 mvm_enable", 128'(mvm_enable), 128'h0);

    // start together with abort is ignored
    seq_len = 8'd2; clink_start = 1'b1; clink_abort = 1'b1;
    tick();
    clink_start = 1'b0; clink_abort = 1'b0;
    chk("start+abort busy", 128'(clink_busy), 128'h0);
    chk("start+abort in_d", 128'(in_d), 128'hC001);
    chk("start+abort step_cnt", 128'(step_cnt), 128'h1);

    // reset mid-run clears everything including weights
    clink_start = 1'b1;
    tick();
    clink_start = 1'b0;
    repeat (40) tick();
    chk("mid busy", 128'(clink_busy), 128'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid-rst busy", 128'(clink_busy), 128'h0);
    chk("mid-rst rec_w", 128'(rec_w), 128'h0);
    chk("mid-rst in_d/h", 128'({in_d, h_pre_d}), 128'h0);
    chk("mid-rst counters", 128'({step_cnt, weight_addr, iter_n, curr_s}), 128'h0);
    tick();
    chk("mid-rst stays idle", 128'({clink_busy, mvm_enable}), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
